branch_condition_unit: RTL and testbench

- Consumer side of the processor flag register: reads the registered 4-bit flag vector and resolves conditional-branch requests from the control unit into a taken/not-taken decision.
- Interlocks against in-flight flag writes: if a flag group needed by the condition is being written on the current edge, the decision waits for the updated value.
- Returns the result over a valid/ready handshake.
- Keeps saturating taken-branch and interlock-stall counters for the debug wrapper.

---
 rtl/branch_condition_unit.sv | 150 +++++++++++++++
 tb/tb_branch_condition_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/branch_condition_unit.sv
// Branch condition unit: resolves a latched condition code against the flag
// register, interlocking on in-flight flag writes, and returns the decision
// over a valid/ready handshake. Saturating taken/stall counters for debug.
module branch_condition_unit #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 CLR,
  input  logic [3:0]           FLAG_IN,     // [3]=N [2]=Z [1]=C [0]=V
  input  logic [2:0]           FLAG_WR_EN,  // [0]=N,Z [1]=C [2]=V
  input  logic                 BR_REQ,
  input  logic [3:0]           BR_COND,
  input  logic                 BR_READY,
  output logic                 BR_VALID,
  output logic                 BR_TAKEN,
  output logic                 BUSY,
  output logic [CNT_WIDTH-1:0] TAKEN_CNT,
  output logic [CNT_WIDTH-1:0] STALL_CNT
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  state_t               state_q, state_d;
  logic [3:0]           cond_q, cond_d;
  logic                 valid_q, valid_d;
  logic                 taken_q, taken_d;
  logic [CNT_WIDTH-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic                 cond_true;
  logic [2:0]           cond_mask;
  logic                 interlock;

  // Evaluate the latched condition against the current flag vector
  always_comb begin
    logic n, z, c, v;
    n = FLAG_IN[3];
    z = FLAG_IN[2];
    c = FLAG_IN[1];
    v = FLAG_IN[0];
    cond_true = 1'b0;
    case (cond_q)
      4'h0: cond_true = z;
      4'h1: cond_true = !z;
      4'h2: cond_true = c;
      4'h3: cond_true = !c;
      4'h4: cond_true = n;
      4'h5: cond_true = !n;
      4'h6: cond_true = v;
      4'h7: cond_true = !v;
      4'h8: cond_true = c && !z;
      4'h9: cond_true = !c || z;
      4'hA: cond_true = (n == v);
      4'hB: cond_true = (n != v);
      4'hC: cond_true = !z && (n == v);
      4'hD: cond_true = z || (n != v);
      4'hE: cond_true = 1'b1;
      4'hF: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  // Flag groups the latched condition depends on; a write to any of them
  // this cycle means FLAG_IN is about to change, so the decision must wait
  always_comb begin
    cond_mask = 3'b000;
    case (cond_q)
      4'h0, 4'h1, 4'h4, 4'h5: cond_mask = 3'b001;
      4'h2, 4'h3:             cond_mask = 3'b010;
      4'h6, 4'h7:             cond_mask = 3'b100;
      4'h8, 4'h9:             cond_mask = 3'b011;
      4'hA, 4'hB, 4'hC, 4'hD: cond_mask = 3'b101;
      default:                cond_mask = 3'b000;
    endcase
    interlock = |(FLAG_WR_EN & cond_mask);
  end

  // Next-state logic: accept in IDLE, resolve or stall in CHECK, hold in RESP
  always_comb begin
    state_d     = state_q;
    cond_d      = cond_q;
    valid_d     = valid_q;
    taken_d     = taken_q;
    taken_cnt_d = taken_cnt_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (BR_REQ) begin
          cond_d  = BR_COND;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (interlock) begin
          if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end else begin
          taken_d = cond_true;
          valid_d = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // Result is frozen until the consumer takes it
        if (BR_READY) begin
          if (taken_q && (taken_cnt_q != CNT_MAX)) taken_cnt_d = taken_cnt_q + CNT_WIDTH'(1);
          valid_d = 1'b0;
          taken_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        taken_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any in-flight request
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q     <= S_IDLE;
      cond_q      <= 4'h0;
      valid_q     <= 1'b0;
      taken_q     <= 1'b0;
      taken_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cond_q      <= cond_d;
      valid_q     <= valid_d;
      taken_q     <= taken_d;
      taken_cnt_q <= taken_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign BR_VALID  = valid_q;
  assign BR_TAKEN  = taken_q;
  assign BUSY      = (state_q != S_IDLE);
  assign TAKEN_CNT = taken_cnt_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: tb/tb_branch_condition_unit.sv
// Bench for branch_condition_unit: directed vector table, reset abort,
// full condition sweep and counter saturation on a narrow-counter instance.
module tb_branch_condition_unit;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] flag_in;
  logic [2:0] flag_wr_en;
  logic       br_req;
  logic [3:0] br_cond;
  logic       br_ready;

  logic       v8, t8, b8;
  logic [7:0] tc8, sc8;
  logic       v2, t2, b2;
  logic [1:0] tc2, sc2;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_tc = 0;
  int exp_sc = 0;

  always #5 clk = ~clk;

  branch_condition_unit #(.CNT_WIDTH(8)) dut (
    .CLK(clk), .CLR(clr), .FLAG_IN(flag_in), .FLAG_WR_EN(flag_wr_en),
    .BR_REQ(br_req), .BR_COND(br_cond), .BR_READY(br_ready),
    .BR_VALID(v8), .BR_TAKEN(t8), .BUSY(b8), .TAKEN_CNT(tc8), .STALL_CNT(sc8)
  );

  branch_condition_unit #(.CNT_WIDTH(2)) dut2 (
    .CLK(clk), .CLR(clr), .FLAG_IN(flag_in), .FLAG_WR_EN(flag_wr_en),
    .BR_REQ(br_req), .BR_COND(br_cond), .BR_READY(br_ready),
    .BR_VALID(v2), .BR_TAKEN(t2), .BUSY(b2), .TAKEN_CNT(tc2), .STALL_CNT(sc2)
  );

  typedef struct {
    logic [3:0] c;
    logic [3:0] f0;   // flags during the first CHECK cycle
    logic [2:0] wr;   // flag write enables during the first CHECK cycle
    logic [3:0] f1;   // flags after that write lands
    int         wt;   // cycles of BR_READY=0 in RESP
    logic       tk;
    int         lat;
    int         st;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: conditions come in pairs, odd code is the complement
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, b;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: b = z;
      3'd1: b = cy;
      3'd2: b = n;
      3'd3: b = v;
      3'd4: b = cy & ~z;
      3'd5: b = (n == v);
      3'd6: b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return b ^ c[0];
  endfunction

  // Caller is at a negedge with the DUT in IDLE; returns at a negedge in IDLE
  task automatic run_br(input string nm, input logic [3:0] c, input logic [3:0] f0,
                        input logic [2:0] wr, input logic [3:0] f1, input int wt,
                        output logic tk, output int lat);
    int n;
    br_req = 1'b1; br_cond = c; flag_in = f0; flag_wr_en = 3'b000; br_ready = 1'b0;
    @(negedge clk);
    n = 1;
    // changing BR_COND after accept must not matter
    br_req = 1'b0; br_cond = ~c; flag_wr_en = wr;
    do begin
      @(negedge clk);
      n++;
      if (!v8) begin flag_wr_en = 3'b000; flag_in = f1; end
    end while (!v8 && n < 20);
    flag_wr_en = 3'b000; flag_in = f1;
    lat = n;
    tk = t8;
    for (int i = 0; i < wt; i++) begin
      br_req = i[0]; br_cond = i[3:0];
      @(negedge clk);
      check({nm, "_hold_valid"}, v8, 1);
      check({nm, "_hold_taken"}, t8, tk);
    end
    br_req = 1'b0; br_ready = 1'b1;
    @(negedge clk);
    br_ready = 1'b0;
    check({nm, "_post_valid"}, v8, 0);
    check({nm, "_post_busy"}, b8, 0);
  endtask

  initial begin
    logic tk;
    int   lat;

    vecs[0]  = '{4'h0, 4'b0100, 3'b000, 4'b0100, 0, 1'b1, 2, 0}; // EQ Z=1
    vecs[1]  = '{4'hA, 4'b0000, 3'b100, 4'b0001, 0, 1'b0, 3, 1}; // GE, V written
    vecs[2]  = '{4'h2, 4'b0010, 3'b101, 4'b0000, 0, 1'b1, 2, 0}; // CS, unrelated write
    vecs[3]  = '{4'h8, 4'b0010, 3'b000, 4'b0010, 5, 1'b1, 2, 0}; // HI, backpressure
    vecs[4]  = '{4'h0, 4'b0000, 3'b000, 4'b0000, 0, 1'b0, 2, 0}; // EQ cleared flags
    vecs[5]  = '{4'h1, 4'b0000, 3'b000, 4'b0000, 0, 1'b1, 2, 0}; // NE cleared flags
    vecs[6]  = '{4'hB, 4'b1000, 3'b001, 4'b1001, 0, 1'b0, 3, 1}; // LT, N/Z write
    vecs[7]  = '{4'hE, 4'b0000, 3'b111, 4'b1111, 0, 1'b1, 2, 0}; // AL never stalls
    vecs[8]  = '{4'hF, 4'b1111, 3'b111, 4'b0000, 0, 1'b0, 2, 0}; // NV never stalls
    vecs[9]  = '{4'h6, 4'b0001, 3'b011, 4'b0000, 0, 1'b1, 2, 0}; // VS, unrelated write
    vecs[10] = '{4'h9, 4'b0010, 3'b010, 4'b0110, 0, 1'b1, 3, 1}; // LS, C write
    vecs[11] = '{4'hD, 4'b1001, 3'b000, 4'b1001, 0, 1'b0, 2, 0}; // LE
    vecs[12] = '{4'hC, 4'b1001, 3'b000, 4'b1001, 0, 1'b1, 2, 0}; // GT
    vecs[13] = '{4'h5, 4'b1000, 3'b110, 4'b0000, 2, 1'b0, 2, 0}; // PL, unrelated write

    clr = 1'b1; flag_in = 4'h0; flag_wr_en = 3'b000;
    br_req = 1'b0; br_cond = 4'h0; br_ready = 1'b0;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    check("rst_valid", v8, 0);
    check("rst_taken", t8, 0);
    check("rst_busy", b8, 0);
    check("rst_tcnt", tc8, 0);
    check("rst_scnt", sc8, 0);

    // directed vector table
    for (int i = 0; i < 14; i++) begin
      run_br($sformatf("vec%0d", i), vecs[i].c, vecs[i].f0, vecs[i].wr, vecs[i].f1,
             vecs[i].wt, tk, lat);
      check($sformatf("vec%0d_taken", i), tk, vecs[i].tk);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      if (vecs[i].tk) exp_tc++;
      exp_sc += vecs[i].st;
      check($sformatf("vec%0d_tcnt", i), tc8, exp_tc);
      check($sformatf("vec%0d_scnt", i), sc8, exp_sc);
    end

    // reset while holding a result in RESP: outputs drop without a clock edge
    br_req = 1'b1; br_cond = 4'hE; flag_in = 4'h0;
    @(negedge clk);
    br_req = 1'b0;
    @(negedge clk);
    check("mid_valid_before", v8, 1);
    check("mid_taken_before", t8, 1);
    #2 clr = 1'b1;
    #1;
    check("async_valid", v8, 0);
    check("async_taken", t8, 0);
    check("async_busy", b8, 0);
    check("async_tcnt", tc8, 0);
    check("async_scnt", sc8, 0);
    @(negedge clk);
    clr = 1'b0;
    exp_tc = 0; exp_sc = 0;
    @(negedge clk);
    check("after_rst_busy", b8, 0);
    check("after_rst_valid", v8, 0);

    // full condition x flag sweep
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        run_br("sweep", 4'(c), 4'(f), 3'b000, 4'(f), 0, tk, lat);
        check($sformatf("sweep_c%0h_f%0h", c, f), tk, ref_cond(4'(c), 4'(f)));
        if (ref_cond(4'(c), 4'(f)) && exp_tc < 255) exp_tc++;
      end
    end
    check("sweep_tcnt", tc8, exp_tc);
    check("sweep_scnt", sc8, 0);

    // counter saturation on the 2-bit instance
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) run_br("al", 4'hE, 4'h0, 3'b000, 4'h0, 0, tk, lat);
    check("sat_tcnt2", tc2, 3);
    check("sat_tcnt8", tc8, 5);
    for (int i = 0; i < 3; i++) run_br("nv", 4'hF, 4'h0, 3'b000, 4'h0, 0, tk, lat);
    check("nv_tcnt2", tc2, 3);
    check("nv_tcnt8", tc8, 5);
    for (int i = 0; i < 4; i++) run_br("lt_stall", 4'hB, 4'h0, 3'b100, 4'h0, 0, tk, lat);
    check("sat_scnt2", sc2, 3);
    check("sat_scnt8", sc8, 4);
    check("stall_tcnt8", tc8, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
